mir_memwait_reg: RTL and testbench
==================================

Name: mir_memwait_reg

Overview:
Parametrised microinstruction register for the microcoded datapath. It latches the microword from control store and splits it into datapath control fields. It also holds the word stable across memory wait states using a ready handshake and an optional timeout. It supports flush-to-NOP and sits between control store and the datapath/CS address logic, which it stalls while memory is busy.

Parameters:
REG_BUS_WIDTH, 6, width of A/B/C register-select fields
ALU_BUS_WIDTH, 4, ALU function field width
COND_BUS_WIDTH, 3, branch condition field width
JUMP_ADDR_BUS_WIDTH, 11, jump address field width
MIR_BUS_WIDTH, 3*REG_BUS_WIDTH+5+ALU_BUS_WIDTH+COND_BUS_WIDTH+JUMP_ADDR_BUS_WIDTH (41), microword width; derived, not overridden
MEM_TIMEOUT, 15, max wait cycles before error; 0 = timeout disabled

Ports:
MIRP_CLOCK_50  in  1  clock; all state updates on falling edge
SC_RegMIRP_Reset_InHigh  in  1  asynchronous, active-high reset
MIRP_Microinstruccion_IN  in  MIR_BUS_WIDTH  microword from control store
MIRP_Load_InHigh  in  1  capture microword this edge
MIRP_Flush_InHigh  in  1  replace held word with NOP
MIRP_MemReady_InHigh  in  1  memory access complete
MIRP_A_OUT / MIRP_B_OUT / MIRP_C_OUT  out  REG_BUS_WIDTH each  register selects
MIRP_AMUX_OUT / MIRP_BMUX_OUT / MIRP_CMUX_OUT  out  1 each  mux selects
MIRP_RD_OUT / MIRP_WR_OUT  out  1 each  memory read/write
MIRP_ALU_OUT  out  ALU_BUS_WIDTH  ALU function
MIRP_COND_OUT  out  COND_BUS_WIDTH  branch condition
MIRP_JUMP_ADDR_OUT  out  JUMP_ADDR_BUS_WIDTH  jump address
MIRP_Valid_OUT  out  1  held word is a real, loaded microword
MIRP_Stall_OUT  out  1  freeze microsequencer
MIRP_Timeout_OUT  out  1  sticky memory timeout error

Behaviour:
- Interface: one clock, MIRP_CLOCK_50. Reset SC_RegMIRP_Reset_InHigh is asynchronous and active-high.
- Field packing, MSB to LSB: A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, JUMP_ADDR.
- Default bit positions: A[40:35], AMUX 34, B[33:28], BMUX 27, C[26:21], CMUX 20, RD 19, WR 18, ALU[17:14], COND[13:11], JUMP[10:0].
- NOP = all-zero microword.
- Reset, taking effect immediately:
  - All fields = 0; Valid = 0; Stall = 0; Timeout = 0.
  - State = RUN; wait counter = 0.
- All field outputs come directly from one MIR_BUS_WIDTH register with no combinational path from the input. Latency is 1 falling edge.
- RUN state (Stall = 0):
  - If Flush: held word = NOP, Valid = 0, stay in RUN.
  - Else if Load: held word = input, Valid = 1. If input RD|WR = 1, go to MEMWAIT and clear the counter.
  - Else: hold the word.
  - MemReady is ignored in RUN.
- MEMWAIT state (Stall = 1, a registered decode of state):
  - Held word is frozen and Load is ignored.
  - Priority per edge: Flush > MemReady > timeout > count.
  - Flush: word = NOP, Valid = 0, go to RUN; aborts the access.
  - MemReady = 1: go to RUN with the word unchanged. Stall drops on the same edge, so the next Load is accepted one edge later.
  - If MEM_TIMEOUT > 0 and the counter equals MEM_TIMEOUT-1 without ready: go to ERROR.
  - Otherwise: counter += 1. The counter is $clog2(MEM_TIMEOUT+1) bits wide and never wraps.
  - RD and WR both set is treated as a single access.
- ERROR state:
  - Word = NOP, Valid = 0, Stall = 1, Timeout = 1.
  - Load, Flush and MemReady are all ignored; only reset exits.
- Reset asserted mid-wait: immediate return to the reset values; no pending access survives.
- With MEM_TIMEOUT = 0 the counter is unused and MEMWAIT exits only on MemReady or Flush.

Decomposition:
- Shared package mir_pkg holds:
  - field widths, field LSB offsets and derived MIR_BUS_WIDTH;
  - MIR_NOP constant;
  - state encoding RUN=2'd0, MEMWAIT=2'd1, ERROR=2'd2.
- One natural sub-module: mir_wait_timer. It is a saturating counter with clear/enable and a terminal flag at MEM_TIMEOUT-1, instantiated only when MEM_TIMEOUT > 0.

Test Plan:
- Reset, then Load with A=5, ALU=4'h3, RD=WR=0 -> after 1 falling edge A_OUT=5, ALU_OUT=3, Valid=1, Stall=0.
- Load with RD=1, JUMP=11'h7FF; MemReady low for 4 edges, then high -> Stall=1 for exactly those edges with fields frozen and new Loads ignored. Stall=0 after the ready edge; a Load on the next edge is captured.
- Load with WR=1, MemReady never asserted (MEM_TIMEOUT=15) -> Timeout=1 and all fields 0 after the 15th wait edge. It stays so despite Load/Flush until reset.
- In MEMWAIT, assert Flush and MemReady on the same edge -> NOP, Valid=0, RUN; Timeout stays 0.
- Assert async reset between clock edges during MEMWAIT -> outputs zero immediately, without waiting for an edge. After release, a Load with RD=0 proceeds normally.
- MEM_TIMEOUT=0 build, RD access held 100 edges without ready -> Stall stays 1 and Timeout stays 0.

Source files
------------

// File: rtl/mir_pkg.sv
// Shared definitions for the microinstruction register: default field widths,
// microword layout, the NOP word and the wait-state FSM encoding.
package mir_pkg;

  localparam int unsigned REG_W  = 6;
  localparam int unsigned ALU_W  = 4;
  localparam int unsigned COND_W = 3;
  localparam int unsigned JUMP_W = 11;

  // Control bits between the register selects and the ALU field
  localparam int unsigned CTRL_BITS = 5;

  localparam int unsigned MIR_W = 3 * REG_W + CTRL_BITS + ALU_W + COND_W + JUMP_W;

  // Field LSB offsets, packed MSB to LSB: A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, JUMP
  localparam int unsigned JUMP_LSB = 0;
  localparam int unsigned COND_LSB = JUMP_LSB + JUMP_W;
  localparam int unsigned ALU_LSB  = COND_LSB + COND_W;
  localparam int unsigned WR_BIT   = ALU_LSB + ALU_W;
  localparam int unsigned RD_BIT   = WR_BIT + 1;
  localparam int unsigned CMUX_BIT = RD_BIT + 1;
  localparam int unsigned C_LSB    = CMUX_BIT + 1;
  localparam int unsigned BMUX_BIT = C_LSB + REG_W;
  localparam int unsigned B_LSB    = BMUX_BIT + 1;
  localparam int unsigned AMUX_BIT = B_LSB + REG_W;
  localparam int unsigned A_LSB    = AMUX_BIT + 1;

  localparam logic [MIR_W-1:0] MIR_NOP = '0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERROR   = 2'd2
  } mir_state_e;

endpackage

// File: rtl/mir_wait_timer.sv
// Saturating memory wait-cycle counter; flags the last allowed wait cycle.
module mir_wait_timer
  import mir_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal_c
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  // Counts on the falling edge alongside the MIR; holds at MEM_TIMEOUT instead of wrapping
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_W'(MEM_TIMEOUT))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_terminal_c = (r_count == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mir_memwait_reg.sv
// Microinstruction register: latches the control-store word, splits it into
// datapath fields and freezes it while a memory access is outstanding.
module mir_memwait_reg
  import mir_pkg::*;
#(
  parameter int unsigned REG_BUS_WIDTH       = REG_W,
  parameter int unsigned ALU_BUS_WIDTH       = ALU_W,
  parameter int unsigned COND_BUS_WIDTH      = COND_W,
  parameter int unsigned JUMP_ADDR_BUS_WIDTH = JUMP_W,
  parameter int unsigned MEM_TIMEOUT         = 15,
  localparam int unsigned MIR_BUS_WIDTH      = 3 * REG_BUS_WIDTH + CTRL_BITS + ALU_BUS_WIDTH
                                               + COND_BUS_WIDTH + JUMP_ADDR_BUS_WIDTH
) (
  input  logic                           MIRP_CLOCK_50,
  input  logic                           SC_RegMIRP_Reset_InHigh,
  input  logic [MIR_BUS_WIDTH-1:0]       MIRP_Microinstruccion_IN,
  input  logic                           MIRP_Load_InHigh,
  input  logic                           MIRP_Flush_InHigh,
  input  logic                           MIRP_MemReady_InHigh,
  output logic [REG_BUS_WIDTH-1:0]       MIRP_A_OUT,
  output logic [REG_BUS_WIDTH-1:0]       MIRP_B_OUT,
  output logic [REG_BUS_WIDTH-1:0]       MIRP_C_OUT,
  output logic                           MIRP_AMUX_OUT,
  output logic                           MIRP_BMUX_OUT,
  output logic                           MIRP_CMUX_OUT,
  output logic                           MIRP_RD_OUT,
  output logic                           MIRP_WR_OUT,
  output logic [ALU_BUS_WIDTH-1:0]       MIRP_ALU_OUT,
  output logic [COND_BUS_WIDTH-1:0]      MIRP_COND_OUT,
  output logic [JUMP_ADDR_BUS_WIDTH-1:0] MIRP_JUMP_ADDR_OUT,
  output logic                           MIRP_Valid_OUT,
  output logic                           MIRP_Stall_OUT,
  output logic                           MIRP_Timeout_OUT
);

  // Field offsets re-derived from this instance's widths
  localparam int unsigned L_JUMP = 0;
  localparam int unsigned L_COND = L_JUMP + JUMP_ADDR_BUS_WIDTH;
  localparam int unsigned L_ALU  = L_COND + COND_BUS_WIDTH;
  localparam int unsigned L_WR   = L_ALU + ALU_BUS_WIDTH;
  localparam int unsigned L_RD   = L_WR + 1;
  localparam int unsigned L_CMUX = L_RD + 1;
  localparam int unsigned L_C    = L_CMUX + 1;
  localparam int unsigned L_BMUX = L_C + REG_BUS_WIDTH;
  localparam int unsigned L_B    = L_BMUX + 1;
  localparam int unsigned L_AMUX = L_B + REG_BUS_WIDTH;
  localparam int unsigned L_A    = L_AMUX + 1;

  localparam logic [MIR_BUS_WIDTH-1:0] NOP_WORD = '0;

  mir_state_e               r_state;
  logic [MIR_BUS_WIDTH-1:0] r_mir;
  logic                     r_valid;
  logic                     r_stall;
  logic                     r_timeout;

  logic w_mem_access;
  logic w_tmr_clear;
  logic w_tmr_enable;
  logic w_tmr_terminal;

  assign w_mem_access = MIRP_Microinstruccion_IN[L_RD] | MIRP_Microinstruccion_IN[L_WR];
  assign w_tmr_clear  = (r_state == ST_RUN) && !MIRP_Flush_InHigh && MIRP_Load_InHigh && w_mem_access;
  assign w_tmr_enable = (r_state == ST_MEMWAIT) && !MIRP_Flush_InHigh && !MIRP_MemReady_InHigh;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timer
      mir_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
      ) u_wait_timer (
        .i_clk        (MIRP_CLOCK_50),
        .i_rst        (SC_RegMIRP_Reset_InHigh),
        .i_clear      (w_tmr_clear),
        .i_enable     (w_tmr_enable),
        .o_terminal_c (w_tmr_terminal)
      );
    end else begin : g_no_timer
      // Timeout disabled: MEMWAIT leaves only on ready or flush
      assign w_tmr_terminal = 1'b0;
    end
  endgenerate

  // Wait-state FSM; stall and timeout are registered alongside the next state
  always_ff @(negedge MIRP_CLOCK_50 or posedge SC_RegMIRP_Reset_InHigh) begin
    if (SC_RegMIRP_Reset_InHigh) begin
      r_state   <= ST_RUN;
      r_mir     <= NOP_WORD;
      r_valid   <= 1'b0;
      r_stall   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (MIRP_Flush_InHigh) begin
            r_mir   <= NOP_WORD;
            r_valid <= 1'b0;
          end else if (MIRP_Load_InHigh) begin
            r_mir   <= MIRP_Microinstruccion_IN;
            r_valid <= 1'b1;
            if (w_mem_access) begin
              r_state <= ST_MEMWAIT;
              r_stall <= 1'b1;
            end
          end
        end

        ST_MEMWAIT: begin
          if (MIRP_Flush_InHigh) begin
            r_state <= ST_RUN;
            r_stall <= 1'b0;
            r_mir   <= NOP_WORD;
            r_valid <= 1'b0;
          end else if (MIRP_MemReady_InHigh) begin
            r_state <= ST_RUN;
            r_stall <= 1'b0;
          end else if (w_tmr_terminal) begin
            r_state   <= ST_ERROR;
            r_mir     <= NOP_WORD;
            r_valid   <= 1'b0;
            r_timeout <= 1'b1;
          end
        end

        ST_ERROR: begin
          r_mir     <= NOP_WORD;
          r_valid   <= 1'b0;
          r_stall   <= 1'b1;
          r_timeout <= 1'b1;
        end

        default: begin
          r_state   <= ST_RUN;
          r_mir     <= NOP_WORD;
          r_valid   <= 1'b0;
          r_stall   <= 1'b0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign MIRP_A_OUT         = r_mir[L_A +: REG_BUS_WIDTH];
  assign MIRP_AMUX_OUT      = r_mir[L_AMUX];
  assign MIRP_B_OUT         = r_mir[L_B +: REG_BUS_WIDTH];
  assign MIRP_BMUX_OUT      = r_mir[L_BMUX];
  assign MIRP_C_OUT         = r_mir[L_C +: REG_BUS_WIDTH];
  assign MIRP_CMUX_OUT      = r_mir[L_CMUX];
  assign MIRP_RD_OUT        = r_mir[L_RD];
  assign MIRP_WR_OUT        = r_mir[L_WR];
  assign MIRP_ALU_OUT       = r_mir[L_ALU +: ALU_BUS_WIDTH];
  assign MIRP_COND_OUT      = r_mir[L_COND +: COND_BUS_WIDTH];
  assign MIRP_JUMP_ADDR_OUT = r_mir[L_JUMP +: JUMP_ADDR_BUS_WIDTH];
  assign MIRP_Valid_OUT     = r_valid;
  assign MIRP_Stall_OUT     = r_stall;
  assign MIRP_Timeout_OUT   = r_timeout;

endmodule

// File: tb/tb_mir_memwait_reg.sv
// Bench for mir_memwait_reg: a default build and a MEM_TIMEOUT=0 build share
// stimulus and are each compared against a behavioural model after every falling edge.
module tb_mir_memwait_reg;

  localparam int unsigned W = 41;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic         flush;
  logic         ready;
  logic [W-1:0] din;

  logic [5:0]  a_o [2];
  logic [5:0]  b_o [2];
  logic [5:0]  c_o [2];
  logic        amux_o [2];
  logic        bmux_o [2];
  logic        cmux_o [2];
  logic        rd_o [2];
  logic        wr_o [2];
  logic [3:0]  alu_o [2];
  logic [2:0]  cond_o [2];
  logic [10:0] jump_o [2];
  logic        valid_o [2];
  logic        stall_o [2];
  logic        tmo_o [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mir_memwait_reg dut (
    .MIRP_CLOCK_50            (clk),
    .SC_RegMIRP_Reset_InHigh  (rst),
    .MIRP_Microinstruccion_IN (din),
    .MIRP_Load_InHigh         (load),
    .MIRP_Flush_InHigh        (flush),
    .MIRP_MemReady_InHigh     (ready),
    .MIRP_A_OUT               (a_o[0]),
    .MIRP_B_OUT               (b_o[0]),
    .MIRP_C_OUT               (c_o[0]),
    .MIRP_AMUX_OUT            (amux_o[0]),
    .MIRP_BMUX_OUT            (bmux_o[0]),
    .MIRP_CMUX_OUT            (cmux_o[0]),
    .MIRP_RD_OUT              (rd_o[0]),
    .MIRP_WR_OUT              (wr_o[0]),
    .MIRP_ALU_OUT             (alu_o[0]),
    .MIRP_COND_OUT            (cond_o[0]),
    .MIRP_JUMP_ADDR_OUT       (jump_o[0]),
    .MIRP_Valid_OUT           (valid_o[0]),
    .MIRP_Stall_OUT           (stall_o[0]),
    .MIRP_Timeout_OUT         (tmo_o[0])
  );

  mir_memwait_reg #(.MEM_TIMEOUT(0)) dut0 (
    .MIRP_CLOCK_50            (clk),
    .SC_RegMIRP_Reset_InHigh  (rst),
    .MIRP_Microinstruccion_IN (din),
    .MIRP_Load_InHigh         (load),
    .MIRP_Flush_InHigh        (flush),
    .MIRP_MemReady_InHigh     (ready),
    .MIRP_A_OUT               (a_o[1]),
    .MIRP_B_OUT               (b_o[1]),
    .MIRP_C_OUT               (c_o[1]),
    .MIRP_AMUX_OUT            (amux_o[1]),
    .MIRP_BMUX_OUT            (bmux_o[1]),
    .MIRP_CMUX_OUT            (cmux_o[1]),
    .MIRP_RD_OUT              (rd_o[1]),
    .MIRP_WR_OUT              (wr_o[1]),
    .MIRP_ALU_OUT             (alu_o[1]),
    .MIRP_COND_OUT            (cond_o[1]),
    .MIRP_JUMP_ADDR_OUT       (jump_o[1]),
    .MIRP_Valid_OUT           (valid_o[1]),
    .MIRP_Stall_OUT           (stall_o[1]),
    .MIRP_Timeout_OUT         (tmo_o[1])
  );

  // Reference model: mode 0 = running, 1 = waiting on memory, 2 = timed out
  logic [W-1:0] m_word  [2];
  logic         m_valid [2];
  int           m_mode  [2];
  int           m_wait  [2];
  int           m_limit [2] = '{15, 0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_word[k]  = '0;
      m_valid[k] = 1'b0;
      m_mode[k]  = 0;
      m_wait[k]  = 0;
    end
  endtask

  task automatic model_step(input logic l, input logic f, input logic r, input logic [W-1:0] w);
    for (int k = 0; k < 2; k++) begin
      if (m_mode[k] == 0) begin
        if (f) begin
          m_word[k] = '0; m_valid[k] = 1'b0;
        end else if (l) begin
          m_word[k] = w; m_valid[k] = 1'b1;
          if (w[19] || w[18]) begin
            m_mode[k] = 1; m_wait[k] = 0;
          end
        end
      end else if (m_mode[k] == 1) begin
        if (f) begin
          m_word[k] = '0; m_valid[k] = 1'b0; m_mode[k] = 0;
        end else if (r) begin
          m_mode[k] = 0;
        end else if (m_limit[k] > 0 && m_wait[k] == m_limit[k] - 1) begin
          m_mode[k] = 2; m_word[k] = '0; m_valid[k] = 1'b0;
        end else begin
          m_wait[k] = m_wait[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] obs_word(input int k);
    return {a_o[k], amux_o[k], b_o[k], bmux_o[k], c_o[k], cmux_o[k], rd_o[k], wr_o[k],
            alu_o[k], cond_o[k], jump_o[k]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s[%0d].word", tag, k), 64'(obs_word(k)), 64'(m_word[k]));
      check($sformatf("%s[%0d].valid", tag, k), 64'(valid_o[k]), 64'(m_valid[k]));
      check($sformatf("%s[%0d].stall", tag, k), 64'(stall_o[k]), 64'(m_mode[k] != 0));
      check($sformatf("%s[%0d].timeout", tag, k), 64'(tmo_o[k]), 64'(m_mode[k] == 2));
    end
  endtask

  // Inputs are driven just after a falling edge and checked 1 time unit after the next one
  task automatic step(input string tag, input logic l, input logic f, input logic r,
                      input logic [W-1:0] w);
    load = l; flush = f; ready = r; din = w;
    @(negedge clk);
    model_step(l, f, r, w);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between falling edges
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[W-1:0];
  endfunction

  logic [W-1:0] w;

  initial begin
    rst = 1'b0; load = 1'b0; flush = 1'b0; ready = 1'b0; din = '0;
    #1 rst = 1'b1;
    model_reset();
    #11;
    check_all("reset");
    rst = 1'b0;

    // Plain load: A=5, ALU=3, no memory access
    w = '0; w[40:35] = 6'd5; w[17:14] = 4'h3;
    step("load_plain", 1'b1, 1'b0, 1'b0, w);
    check("a_is_5", 64'(a_o[0]), 64'd5);
    check("alu_is_3", 64'(alu_o[0]), 64'd3);

    // Read access held four edges, loads ignored, then ready
    w = '0; w[19] = 1'b1; w[10:0] = 11'h7FF;
    step("load_rd", 1'b1, 1'b0, 1'b0, w);
    check("jump_7ff", 64'(jump_o[0]), 64'h7FF);
    for (int i = 0; i < 4; i++) step("rd_wait", 1'b1, 1'b0, 1'b0, rand_word());
    step("rd_ready", 1'b1, 1'b0, 1'b1, rand_word());
    check("stall_drop", 64'(stall_o[0]), 64'd0);
    w = '0; w[33:28] = 6'h2A; w[13:11] = 3'd6;
    step("load_after_ready", 1'b1, 1'b0, 1'b0, w);

    // Write access never completes: 15 wait edges then error
    w = '0; w[18] = 1'b1; w[26:21] = 6'h11;
    step("load_wr", 1'b1, 1'b0, 1'b0, w);
    for (int i = 0; i < 14; i++) step("wr_wait", 1'b0, 1'b0, 1'b0, '0);
    check("no_timeout_yet", 64'(tmo_o[0]), 64'd0);
    step("wr_timeout", 1'b0, 1'b0, 1'b0, '0);
    check("timeout_set", 64'(tmo_o[0]), 64'd1);
    step("err_load", 1'b1, 1'b0, 1'b0, rand_word());
    step("err_flush", 1'b0, 1'b1, 1'b1, rand_word());
    step("err_ready", 1'b1, 1'b0, 1'b1, rand_word());
    async_reset("err_reset");

    // Flush and ready together in MEMWAIT: flush wins
    w = rand_word(); w[19] = 1'b1;
    step("load_rd2", 1'b1, 1'b0, 1'b0, w);
    step("wait2", 1'b0, 1'b0, 1'b0, '0);
    step("flush_ready", 1'b0, 1'b1, 1'b1, '0);

    // Asynchronous reset in the middle of a wait, then a normal load
    w = rand_word(); w[18] = 1'b1;
    step("load_wr2", 1'b1, 1'b0, 1'b0, w);
    step("wait3", 1'b0, 1'b0, 1'b0, '0);
    async_reset("mid_wait_reset");
    w = rand_word(); w[19:18] = 2'b00;
    step("load_post_reset", 1'b1, 1'b0, 1'b0, w);

    // Long read without ready: the no-timeout build keeps stalling
    w = rand_word(); w[19] = 1'b1; w[18] = 1'b1;
    step("load_long", 1'b1, 1'b0, 1'b0, w);
    for (int i = 0; i < 100; i++) step("long_wait", 1'b0, 1'b0, 1'b0, rand_word());
    check("t0_stall_held", 64'(stall_o[1]), 64'd1);
    check("t0_no_timeout", 64'(tmo_o[1]), 64'd0);
    async_reset("long_reset");

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rand_reset");
      end else begin
        step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 3) == 0), rand_word());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
